spi_controller: RTL and testbench



---
 rtl/spi_controller.sv | 212 +++++++++++++++++++++
 tb/tb_spi_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator issuing 16-bit register-write frames
// ({1'b1, addr[6:0], data[7:0]}, MSB first) from a valid/ready request port.
// Optional feature macro: SPI_CTRL_FIFO_EN selects a 4-entry request FIFO;
// without it a single holding register buffers one request.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be in 2..255");
  end

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        ncs_out_q, sclk_out_q, copi_out_q, done_out_q;

  logic        push, pop, q_empty, q_nonempty_d;
  logic [14:0] q_head;

  assign push = req_valid && ready_q;
  assign pop  = (state_q == IDLE) && !q_empty;

`ifdef SPI_CTRL_FIFO_EN
  logic [14:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;

  assign q_empty      = (count_q == 3'd0);
  assign q_head       = fifo_q[rd_ptr_q];
  assign count_d      = count_q + 3'(push) - 3'(pop);
  assign q_nonempty_d = (count_d != 3'd0);
  assign ready_d      = (count_d != 3'd4);

  // FIFO pointers and occupancy; pointers wrap naturally at 4 entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_addr, req_data};
  end
`else
  logic [14:0] hold_q;
  logic        full_q, full_d;

  // Push needs an empty register and pop a full one, so they never coincide
  always_comb begin
    full_d = full_q;
    if (push)     full_d = 1'b1;
    else if (pop) full_d = 1'b0;
  end

  assign q_empty      = !full_q;
  assign q_head       = hold_q;
  assign q_nonempty_d = full_d;
  assign ready_d      = !full_d;

  // Single holding register for one pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= 15'd0;
    end else begin
      full_q <= full_d;
      if (push) hold_q <= {req_addr, req_data};
    end
  end
`endif

  // Frame sequencing: next state, divider, bit counter and pin levels
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      div_d = (div_q == DivLast) ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        div_d   = 8'd0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        shift_d = 16'd0;
        if (!q_empty) begin
          shift_d = {1'b1, q_head};
          bit_d   = 4'd0;
          ncs_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_q == DivLast) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (div_q == DivLast) begin
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (div_q == DivLast) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HOLD: begin
        if (div_q == DivLast) begin
          ncs_d   = 1'b1;
          shift_d = 16'd0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_q == DivLast) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) || q_nonempty_d;
  end

  // State registers plus an aligned output stage so every pin is a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bit_q      <= 4'd0;
      shift_q    <= 16'd0;
      ncs_q      <= 1'b1;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      ncs_out_q  <= 1'b1;
      sclk_out_q <= 1'b0;
      copi_out_q <= 1'b0;
      done_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ncs_q      <= ncs_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ncs_out_q  <= ncs_q;
      sclk_out_q <= sclk_q;
      copi_out_q <= shift_q[15];
      done_out_q <= done_q;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_out_q;
  assign sclk      = sclk_out_q;
  assign copi      = copi_out_q;
  assign ncs       = ncs_out_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed testbench for spi_controller: a table of single-frame vectors
// plus hand-written back-to-back, streaming and mid-frame reset sequences.
module tb_spi_controller;

  localparam int CLK_DIV = 4;
`ifdef SPI_CTRL_FIFO_EN
  localparam int EXP_ACCEPTS = 5;
`else
  localparam int EXP_ACCEPTS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       req_ready, busy, done, sclk, copi, ncs;

  spi_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .copi      (copi),
    .ncs       (ncs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          nBits;
    int          lowLen;
  } frame_t;

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] expFrame;
  } vec_t;

  frame_t frameQ[$];
  int     readIdx = 0;
  int     errors = 0;
  int     checks = 0;

  int          nBits = 0, lowLen = 0, highLen = 0, doneCount = 0;
  int          sinceRise = 0, doneDist = -1, lastGap = -1, stabErr = 0;
  logic [15:0] shiftIn = 16'd0;
  logic        prevNcs = 1'b1, prevSclk = 1'b0, prevCopi = 1'b0;
  logic        pendingStab = 1'b0, stabCopi = 1'b0, inFrame = 1'b0;

  // Bus monitor on the falling clock edge: decodes frames off the SPI pins,
  // measures ncs low/high spans, done placement and copi stability at rises
  always @(negedge clk) begin
    if (ncs === 1'b0) begin
      if (prevNcs === 1'b1) begin
        lastGap = highLen;
        lowLen  = 0;
        nBits   = 0;
        shiftIn = 16'd0;
      end
      inFrame = 1'b1;
      lowLen++;
      if (sclk === 1'b1 && prevSclk === 1'b0) begin
        shiftIn = {shiftIn[14:0], copi};
        nBits++;
        if (copi !== prevCopi) stabErr++;
        pendingStab = 1'b1;
        stabCopi    = copi;
      end else if (pendingStab) begin
        if (copi !== stabCopi) stabErr++;
        pendingStab = 1'b0;
      end
    end else begin
      inFrame     = 1'b0;
      pendingStab = 1'b0;
      if (prevNcs === 1'b0) begin
        frameQ.push_back('{shiftIn, nBits, lowLen});
        highLen   = 1;
        sinceRise = 0;
      end else begin
        highLen++;
        sinceRise++;
      end
    end
    if (done === 1'b1) begin
      doneCount++;
      doneDist = sinceRise;
    end
    prevNcs  = ncs;
    prevSclk = sclk;
    prevCopi = copi;
  end

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one request and hold it until the accepting clock edge
  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d);
    int w;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    w = 0;
    while (req_ready !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) until the monitor has seen the given number of done pulses
  task automatic waitDone(input int target, input int budget);
    int c;
    c = 0;
    while (doneCount < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    checkOutput("done_count", doneCount, target);
  endtask

  // Next decoded frame from the monitor, or an all-X record if none arrived
  task automatic nextFrame(output frame_t f);
    if (readIdx < frameQ.size()) begin
      f = frameQ[readIdx];
      readIdx++;
    end else begin
      f = '{16'hxxxx, -1, -1};
    end
  endtask

  vec_t   vecs[4];
  vec_t   stream[6];
  frame_t f;
  int     lat, startDone, stab0, acc, idx, guard, c;

  initial begin
    vecs[0] = '{7'h04, 8'h80, 16'h8480};
    vecs[1] = '{7'h7F, 8'h00, 16'hFF00};
    vecs[2] = '{7'h55, 8'hA5, 16'hD5A5};
    vecs[3] = '{7'h2A, 8'h3C, 16'hAA3C};
    for (int i = 0; i < 6; i++) begin
      stream[i].addr     = 7'(8'h10 + i);
      stream[i].data     = 8'(8'h01 + 8'h11 * i);
      stream[i].expFrame = {1'b1, stream[i].addr, stream[i].data};
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ncs", {31'd0, ncs}, 32'd1);
    checkOutput("reset_sclk", {31'd0, sclk}, 32'd0);
    checkOutput("reset_copi", {31'd0, copi}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Table of isolated single frames
    for (int i = 0; i < 4; i++) begin
      startDone = doneCount;
      stab0     = stabErr;
      applyStimulus(vecs[i].addr, vecs[i].data);
      lat = 1;
      @(negedge clk);
      while (ncs !== 1'b0 && lat < 4000) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("accept_to_ncs_latency", lat, 3);
      waitDone(startDone + 1, 1000);
      checkOutput("frames_per_request", frameQ.size() - readIdx, 1);
      nextFrame(f);
      checkOutput("frame_bits", {16'd0, f.bits}, {16'd0, vecs[i].expFrame});
      checkOutput("frame_sclk_rises", f.nBits, 16);
      checkOutput("ncs_low_cycles", f.lowLen, 33 * CLK_DIV);
      checkOutput("done_after_ncs_rise", doneDist, CLK_DIV);
      checkOutput("copi_stable_at_rise", stabErr - stab0, 0);
      readIdx = frameQ.size();
    end

    // Back-to-back frames
    startDone = doneCount;
    applyStimulus(7'h00, 8'hFF);
    applyStimulus(7'h01, 8'h0F);
    waitDone(startDone + 2, 2000);
    nextFrame(f);
    checkOutput("b2b_frame0", {16'd0, f.bits}, 32'h80FF);
    nextFrame(f);
    checkOutput("b2b_frame1", {16'd0, f.bits}, 32'h810F);
    checkOutput("b2b_ncs_high_gap", lastGap, CLK_DIV + 1);
    readIdx = frameQ.size();

    // Stream of six requests with req_valid held high
    startDone = doneCount;
    acc   = 0;
    idx   = 0;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = stream[0].addr;
    req_data  = stream[0].data;
    while (idx < 6 && guard < 5000) begin
      if (req_ready === 1'b1) begin
        @(posedge clk);
        if (doneCount == startDone) acc++;
        idx++;
        #1;
        if (idx < 6) begin
          req_addr = stream[idx].addr;
          req_data = stream[idx].data;
        end else begin
          req_valid = 1'b0;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    req_valid = 1'b0;
    checkOutput("stream_all_accepted", idx, 6);
    checkOutput("accepts_before_first_done", acc, EXP_ACCEPTS);
    waitDone(startDone + 6, 3000);
    for (int i = 0; i < 6; i++) begin
      nextFrame(f);
      checkOutput("stream_frame", {16'd0, f.bits}, {16'd0, stream[i].expFrame});
    end
    readIdx = frameQ.size();

    // Reset after the 8th sclk rise of a frame
    startDone = doneCount;
    applyStimulus(7'h33, 8'h99);
    c = 0;
    while (!(inFrame && nBits == 8) && c < 1000) begin
      @(posedge clk);
      c++;
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_ncs", {31'd0, ncs}, 32'd1);
    checkOutput("midreset_sclk", {31'd0, sclk}, 32'd0);
    checkOutput("midreset_copi", {31'd0, copi}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    checkOutput("midreset_no_done", doneCount, startDone);
    nextFrame(f);
    checkOutput("aborted_frame_rises", f.nBits, 8);
    readIdx = frameQ.size();
    applyStimulus(7'h0C, 8'h5A);
    waitDone(startDone + 1, 1000);
    nextFrame(f);
    checkOutput("post_reset_frame", {16'd0, f.bits}, 32'h8C5A);
    checkOutput("post_reset_rises", f.nBits, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
